// File: rtl/nios2_oci_dct_trace_monitor.sv
// rtl/nios2_oci_dct_trace_monitor.sv - DCT trace record capture FIFO, entry-count checker and end-of-test sequencer
module nios2_oci_dct_trace_monitor #(
    parameter int DCT_W     = 30,
    parameter int CNT_W     = 4,
    parameter int MAX_COUNT = 9,
    parameter int DEPTH     = 16,
    parameter int TOT_W     = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DCT_W-1:0]          dct_buffer,
    input  logic [CNT_W-1:0]          dct_count,
    input  logic                      dct_strobe,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      sw_clear,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [CNT_W+DCT_W-1:0]    rd_data,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic [TOT_W-1:0]          accepted_total,
    output logic [TOT_W-1:0]          dropped_total,
    output logic                      overflow_err,
    output logic                      count_err,
    output logic                      draining,
    output logic                      done
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = CNT_W + DCT_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               full;
    logic               push_req;
    logic               push_ok;
    logic               push_drop;
    logic               pop;
    logic               flush;

    // sw_clear and test_has_ended both empty the FIFO; sw_clear wins when both are high
    assign flush     = sw_clear || test_has_ended;
    assign full      = (level == LVL_W'(DEPTH));

    // DONE hides any contents from the consumer; rd_data reads zero whenever nothing is offered
    assign rd_valid  = (level != '0) && (state_q != ST_DONE);
    assign rd_data   = rd_valid ? mem[rd_ptr] : '0;

    // A pop only happens on an offered record, so push+pop at level 0 is push-only
    assign pop       = rd_valid && rd_ready && !flush;
    assign push_req  = (state_q == ST_RUN) && dct_strobe && !flush;
    assign push_ok   = push_req && (!full || pop);
    assign push_drop = push_req && full && !pop;

    assign fifo_level = level;
    assign draining   = (state_q == ST_DRAIN);
    assign done       = (state_q == ST_DONE);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection in priority order: clear, hard end, graceful end, drain completion
    always_comb begin
        state_d = state_q;
        if (sw_clear) begin
            state_d = ST_RUN;
        end else if (test_has_ended) begin
            state_d = ST_DONE;
        end else begin
            case (state_q)
                ST_RUN:   if (test_ending) state_d = ST_DRAIN;
                ST_DRAIN: if (level == '0) state_d = ST_DONE;
                ST_DONE:  state_d = ST_DONE;
                default:  state_d = ST_RUN;
            endcase
        end
    end

    // Record storage; contents are only visible through rd_data when rd_valid is set
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= {dct_count, dct_buffer};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks occupancy 0..DEPTH
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Saturating totals and sticky error flags; only sw_clear or reset clears them
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accepted_total <= '0;
            dropped_total  <= '0;
            overflow_err   <= 1'b0;
            count_err      <= 1'b0;
        end else if (sw_clear) begin
            accepted_total <= '0;
            dropped_total  <= '0;
            overflow_err   <= 1'b0;
            count_err      <= 1'b0;
        end else begin
            if (push_ok && (accepted_total != '1)) begin
                accepted_total <= accepted_total + TOT_W'(1);
            end
            if (push_drop && (dropped_total != '1)) begin
                dropped_total <= dropped_total + TOT_W'(1);
            end
            if (push_drop) begin
                overflow_err <= 1'b1;
            end
            if (push_ok && (dct_count > CNT_W'(MAX_COUNT))) begin
                count_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_nios2_oci_dct_trace_monitor.sv
// tb/tb_nios2_oci_dct_trace_monitor.sv - directed self-checking bench for nios2_oci_dct_trace_monitor
module tb_nios2_oci_dct_trace_monitor;

    localparam int DCT_W = 30;
    localparam int CNT_W = 4;
    localparam int DEPTH = 16;
    localparam int TOT_W = 16;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic [DCT_W-1:0]        dct_buffer;
    logic [CNT_W-1:0]        dct_count;
    logic                    dct_strobe;
    logic                    test_ending;
    logic                    test_has_ended;
    logic                    sw_clear;
    logic                    rd_ready;
    logic                    rd_valid;
    logic [CNT_W+DCT_W-1:0]  rd_data;
    logic [$clog2(DEPTH):0]  fifo_level;
    logic [TOT_W-1:0]        accepted_total;
    logic [TOT_W-1:0]        dropped_total;
    logic                    overflow_err;
    logic                    count_err;
    logic                    draining;
    logic                    done;

    int checks = 0;
    int errors = 0;

    nios2_oci_dct_trace_monitor #(
        .DCT_W(DCT_W), .CNT_W(CNT_W), .MAX_COUNT(9), .DEPTH(DEPTH), .TOT_W(TOT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
        .dct_strobe(dct_strobe), .test_ending(test_ending), .test_has_ended(test_has_ended),
        .sw_clear(sw_clear), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
        .fifo_level(fifo_level), .accepted_total(accepted_total), .dropped_total(dropped_total),
        .overflow_err(overflow_err), .count_err(count_err), .draining(draining), .done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rec(input int cnt, input int payload);
        logic [CNT_W-1:0] c;
        logic [DCT_W-1:0] p;
        c = CNT_W'(cnt);
        p = DCT_W'(payload);
        return 64'({c, p});
    endfunction

    task automatic strobe(input int cnt, input int payload);
        dct_strobe = 1'b1;
        dct_count  = CNT_W'(cnt);
        dct_buffer = DCT_W'(payload);
    endtask

    task automatic clear_pulse();
        sw_clear = 1'b1;
        tick();
        sw_clear = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; dct_buffer = '0; dct_count = '0; dct_strobe = 1'b0;
        test_ending = 1'b0; test_has_ended = 1'b0; sw_clear = 1'b0; rd_ready = 1'b0;
        #1;
        chk("reset_level", 64'(fifo_level), 0);
        chk("reset_rd_valid", 64'(rd_valid), 0);
        chk("reset_rd_data", 64'(rd_data), 0);
        chk("reset_accepted", 64'(accepted_total), 0);
        chk("reset_dropped", 64'(dropped_total), 0);
        chk("reset_stickies", 64'({overflow_err, count_err}), 0);
        chk("reset_state", 64'({draining, done}), 0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: five records, then in-order read-out
        for (int i = 1; i <= 5; i++) begin
            strobe(3, i);
            tick();
        end
        dct_strobe = 1'b0;
        chk("t1_level", 64'(fifo_level), 5);
        chk("t1_accepted", 64'(accepted_total), 5);
        chk("t1_head", 64'(rd_data), rec(3, 1));
        rd_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            chk("t1_pop_valid", 64'(rd_valid), 1);
            chk("t1_pop_data", 64'(rd_data), rec(3, i));
            tick();
        end
        chk("t1_empty_valid", 64'(rd_valid), 0);
        chk("t1_empty_data", 64'(rd_data), 0);
        rd_ready = 1'b0;

        // 2: overflow, then push+pop at full, then wrap-around read-out
        clear_pulse();
        chk("t2_clear_accepted", 64'(accepted_total), 0);
        for (int i = 1; i <= 20; i++) begin
            strobe(3, 100 + i);
            tick();
        end
        dct_strobe = 1'b0;
        chk("t2_level", 64'(fifo_level), 16);
        chk("t2_accepted", 64'(accepted_total), 16);
        chk("t2_dropped", 64'(dropped_total), 4);
        chk("t2_overflow", 64'(overflow_err), 1);
        strobe(3, 121);
        rd_ready = 1'b1;
        tick();
        dct_strobe = 1'b0;
        rd_ready = 1'b0;
        chk("t2_full_pp_accepted", 64'(accepted_total), 17);
        chk("t2_full_pp_level", 64'(fifo_level), 16);
        chk("t2_full_pp_dropped", 64'(dropped_total), 4);
        chk("t2_hold_data", 64'(rd_data), rec(3, 102));
        rd_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk("t2_wrap_data", 64'(rd_data), rec(3, (j < 15) ? 102 + j : 121));
            tick();
        end
        rd_ready = 1'b0;
        chk("t2_drained_level", 64'(fifo_level), 0);

        // 3: count check at MAX_COUNT boundary
        clear_pulse();
        chk("t3_clear_overflow", 64'(overflow_err), 0);
        strobe(9, 7);
        tick();
        chk("t3_cnt9_err", 64'(count_err), 0);
        strobe(10, 8);
        tick();
        chk("t3_cnt10_err", 64'(count_err), 1);
        chk("t3_cnt10_level", 64'(fifo_level), 2);
        strobe(9, 9);
        tick();
        dct_strobe = 1'b0;
        chk("t3_sticky", 64'(count_err), 1);
        chk("t3_head", 64'(rd_data), rec(9, 7));
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        chk("t3_bad_rec_stored", 64'(rd_data), rec(10, 8));

        // 4: graceful drain
        clear_pulse();
        for (int i = 1; i <= 3; i++) begin
            strobe(3, i);
            tick();
        end
        strobe(3, 4);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("t4_level", 64'(fifo_level), 4);
        chk("t4_draining", 64'(draining), 1);
        chk("t4_accepted", 64'(accepted_total), 4);
        strobe(3, 5);
        tick();
        dct_strobe = 1'b0;
        chk("t4_ignored_level", 64'(fifo_level), 4);
        chk("t4_ignored_accepted", 64'(accepted_total), 4);
        rd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("t4_pop_data", 64'(rd_data), rec(3, k + 1));
            tick();
        end
        chk("t4_zero_level", 64'(fifo_level), 0);
        chk("t4_not_done_yet", 64'({draining, done}), 64'b10);
        tick();
        chk("t4_done", 64'({draining, done}), 64'b01);
        chk("t4_done_valid", 64'(rd_valid), 0);
        rd_ready = 1'b0;

        // 5: immediate end with contents held
        clear_pulse();
        chk("t5_clear_state", 64'({draining, done}), 0);
        chk("t5_clear_stickies", 64'({overflow_err, count_err}), 0);
        for (int i = 1; i <= 6; i++) begin
            strobe(3, i);
            tick();
        end
        chk("t5_level", 64'(fifo_level), 6);
        strobe(3, 7);
        test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
        chk("t5_done", 64'(done), 1);
        chk("t5_level_flushed", 64'(fifo_level), 0);
        chk("t5_accepted", 64'(accepted_total), 6);
        chk("t5_rd_valid", 64'(rd_valid), 0);
        tick();
        dct_strobe = 1'b0;
        chk("t5_done_ignored", 64'(accepted_total), 6);

        // 6: clear from DONE, then async reset mid-drain
        clear_pulse();
        chk("t6_clear_state", 64'({draining, done}), 0);
        chk("t6_clear_accepted", 64'(accepted_total), 0);
        strobe(3, 1);
        tick();
        strobe(3, 2);
        tick();
        dct_strobe = 1'b0;
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("t6_draining", 64'(draining), 1);
        chk("t6_drain_level", 64'(fifo_level), 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_level", 64'(fifo_level), 0);
        chk("t6_async_draining", 64'(draining), 0);
        chk("t6_async_accepted", 64'(accepted_total), 0);
        chk("t6_async_valid", 64'(rd_valid), 0);
        tick();
        reset_n = 1'b1;
        strobe(3, 9);
        tick();
        dct_strobe = 1'b0;
        chk("t6_resume_level", 64'(fifo_level), 1);
        chk("t6_resume_accepted", 64'(accepted_total), 1);
        chk("t6_resume_state", 64'({draining, done}), 0);
        chk("t6_resume_data", 64'(rd_data), rec(3, 9));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
